// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant among ALU/load/link
// requesters, one registered write per cycle, plus a pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         req_vld,
    output logic [2:0]         req_rdy,
    input  logic [14:0]        req_wa,
    input  logic [3*WIDTH-1:0] req_wd,
    output logic               rf_we,
    output logic [4:0]         rf_wa,
    output logic [WIDTH-1:0]   rf_wd,
    input  logic               sb_set,
    input  logic [4:0]         sb_wa,
    output logic [31:0]        busy
);

    localparam logic [1:0] PTR_ALU  = 2'd0;
    localparam logic [1:0] PTR_LOAD = 2'd1;
    localparam logic [1:0] PTR_LINK = 2'd2;

    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [2:0]       grant;
    logic             xfer;
    logic [4:0]       sel_wa;
    logic [WIDTH-1:0] sel_wd;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;

    // Priority rotates so the requester after the last winner is searched first.
    always_comb begin
        grant = '0;
        case (ptr)
            PTR_LOAD: begin
                if (req_vld[1])      grant = 3'b010;
                else if (req_vld[2]) grant = 3'b100;
                else if (req_vld[0]) grant = 3'b001;
            end
            PTR_LINK: begin
                if (req_vld[2])      grant = 3'b100;
                else if (req_vld[0]) grant = 3'b001;
                else if (req_vld[1]) grant = 3'b010;
            end
            default: begin
                if (req_vld[0])      grant = 3'b001;
                else if (req_vld[1]) grant = 3'b010;
                else if (req_vld[2]) grant = 3'b100;
            end
        endcase
    end

    assign req_rdy = rst_n ? grant : '0;
    assign xfer    = |grant;

    always_comb begin
        sel_wa  = '0;
        sel_wd  = '0;
        ptr_nxt = ptr;
        for (int unsigned i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_wa = req_wa[5*i +: 5];
                sel_wd = req_wd[WIDTH*i +: WIDTH];
            end
        end
        case (grant)
            3'b001:  ptr_nxt = PTR_LOAD;
            3'b010:  ptr_nxt = PTR_LINK;
            3'b100:  ptr_nxt = PTR_ALU;
            default: ptr_nxt = ptr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= PTR_ALU;
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            ptr   <= ptr_nxt;
            // Writes to r0 are accepted but never reach the register file.
            rf_we <= xfer && (sel_wa != 5'd0);
            if (xfer) begin
                rf_wa <= sel_wa;
                rf_wd <= sel_wd;
            end
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (sb_set) set_mask[sb_wa] = 1'b1;
        if (rf_we)  clr_mask[rf_wa] = 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of every write-data path.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_vld  input  3  per-requester write-back valid (bit0 ALU, bit1 load, bit2 link).
REQ-005 req_rdy  output  3  per-requester grant/accept, combinational.
REQ-006 req_wa  input  15  destination addresses, requester i at bits [5i+4:5i].
REQ-007 req_wd  input  3*WIDTH  write data, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-008 rf_we  output  1  write enable to register file write port, registered.
REQ-009 rf_wa  output  5  write address to register file, registered.
REQ-010 rf_wd  output  WIDTH  write data to register file, registered.
REQ-011 sb_set  input  1  issue stage marks a destination pending.
REQ-012 sb_wa  input  5  destination address for sb_set.
REQ-013 busy  output  32  scoreboard, bit k = register k has a write outstanding, registered.

Function
REQ-014 The block SHALL hold a round-robin pointer ptr in {0,1,2}; search order ptr, ptr+1, ptr+2 mod 3.
REQ-015 req_rdy SHALL be one-hot on the first valid requester in search order, all-zero when req_vld==0.
REQ-016 A transfer SHALL occur for requester i when req_vld[i]&req_rdy[i]; at most one transfer per cycle.
REQ-017 On a transfer from i, ptr SHALL become (i+1) mod 3 at the next edge; with no transfer ptr SHALL hold.
REQ-018 Latency: a transfer at edge n SHALL drive rf_we, rf_wa, rf_wd with that request during cycle n+1 (one-cycle pulse).
REQ-019 With no transfer, rf_we SHALL be 0 next cycle; rf_wa/rf_wd SHALL hold last values.
REQ-020 A transfer with wa==0 SHALL be accepted (rdy asserted, ptr advances) but SHALL produce rf_we=0.
REQ-021 A requester not granted SHALL see req_rdy[i]=0 and must hold vld/wa/wd; the block SHALL NOT drop or reorder an unaccepted request.
REQ-022 Starvation bound: a continuously valid requester SHALL be granted within 3 cycles.
REQ-023 busy[k] SHALL set at the edge where sb_set==1 and sb_wa==k, k!=0.
REQ-024 busy[k] SHALL clear at the edge ending a cycle where rf_we==1 and rf_wa==k.
REQ-025 Simultaneous set and clear of the same k SHALL leave busy[k]=1 (set wins).
REQ-026 busy[0] SHALL be 0 always; sb_set with sb_wa==0 SHALL be ignored.
REQ-027 Setting an already-busy register SHALL leave it busy (no count; single outstanding write per register).
REQ-028 Input changes on req_vld/req_wa SHALL affect req_rdy within the same cycle; no other output SHALL have a combinational input path.

Reset
REQ-029 While rst_n==0: ptr=0, rf_we=0, rf_wa=0, rf_wd=0, busy=32'h0, req_rdy=0, regardless of clk.
REQ-030 Reset asserted mid-operation SHALL discard the registered write (rf_we forced 0) and all busy bits immediately.
REQ-031 After rst_n deasserts, the first grant SHALL follow ptr=0 ordering.

Verification
REQ-032 Single request: vld=3'b001, wa0=5, wd0=32'hA5A5_0001 -> rdy=001 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=32'hA5A5_0001; following cycle rf_we=0.
REQ-033 Contention: vld=3'b111 held 3 cycles from reset -> grants 0,1,2 in order, ptr returns to 0; rf_wa sequence equals wa0,wa1,wa2.
REQ-034 Zero address: vld=3'b010, wa1=0 -> rdy=010, ptr goes to 2, rf_we stays 0.
REQ-035 Scoreboard: sb_set, sb_wa=7 -> busy[7]=1; then request wa=7 -> busy[7] clears on edge after rf_we pulse; same-cycle sb_set wa=7 with rf_we wa=7 -> busy[7] stays 1.
REQ-036 Async reset: assert rst_n=0 between edges while rf_we=1 and busy=32'h0000_0080 -> rf_we=0, busy=0 immediately; after release vld=3'b110 grants requester 1 first.
